gshare_predictor: RTL

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor.sv | 80 ++++++++
 1 files changed

// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch direction predictor: a table of saturating counters indexed by
// PC bits, optionally XORed with non-speculative global history, plus resolve statistics.
module gshare_predictor #(
  parameter int IDX_BITS = 6,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 6,
  parameter int USE_GHR  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         lookup_pc,
  output logic                predict_taken,
  output logic [IDX_BITS-1:0] predict_index,
  input  logic                update_valid,
  input  logic [IDX_BITS-1:0] update_index,
  input  logic                update_taken,
  input  logic                update_mispredict,
  output logic [GHR_BITS-1:0] ghr,
  output logic [31:0]         branch_cnt,
  output logic [31:0]         mispredict_cnt
);

  localparam int Entries = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] WeakTaken = {1'b1, {(CTR_BITS-1){1'b0}}};

  logic [CTR_BITS-1:0] ctrTable [Entries];
  logic [GHR_BITS-1:0] ghrQ;
  logic [31:0]         branchCntQ;
  logic [31:0]         mispredictCntQ;
  logic [IDX_BITS-1:0] pcIdx;
  logic [IDX_BITS-1:0] histIdx;
  logic [IDX_BITS-1:0] lookupIdx;
  logic                unusedPcBits;

  function automatic logic [CTR_BITS-1:0] ctrNext(input logic [CTR_BITS-1:0] ctr,
                                                   input logic taken);
    if (taken) return (ctr == {CTR_BITS{1'b1}}) ? ctr : ctr + 1'b1;
    else       return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign pcIdx        = lookup_pc[IDX_BITS+1:2];
  assign unusedPcBits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0]};

  generate
    if (GHR_BITS < IDX_BITS) begin : gHistExt
      assign histIdx = {{(IDX_BITS-GHR_BITS){1'b0}}, ghrQ};
    end else begin : gHistTrunc
      assign histIdx = ghrQ[IDX_BITS-1:0];
    end
  endgenerate

  // Lookup: purely combinational, reads the table state before any same-cycle update
  assign lookupIdx     = (USE_GHR != 0) ? (pcIdx ^ histIdx) : pcIdx;
  assign predict_index = lookupIdx;
  assign predict_taken = ctrTable[lookupIdx][CTR_BITS-1];

  // Resolve: counter training, history shift and statistics on the rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) ctrTable[i] <= WeakTaken;
      ghrQ           <= '0;
      branchCntQ     <= '0;
      mispredictCntQ <= '0;
    end else if (update_valid) begin
      ctrTable[update_index] <= ctrNext(ctrTable[update_index], update_taken);
      ghrQ                   <= (ghrQ << 1) | GHR_BITS'(update_taken);
      branchCntQ             <= satInc32(branchCntQ);
      if (update_mispredict) mispredictCntQ <= satInc32(mispredictCntQ);
    end
  end

  assign ghr            = ghrQ;
  assign branch_cnt     = branchCntQ;
  assign mispredict_cnt = mispredictCntQ;

endmodule
